// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Fields are sized for the largest legal pattern (32 bits), so every
// instance shares one config type whatever its MAX_LEN.
package seq_detect_pkg;

   localparam int PAT_W = 32;   // widest legal pattern
   localparam int LEN_W = 6;    // holds lengths 0..32

   // Active detector configuration: pattern (right-aligned), length, overlap mode.
   typedef struct packed {
      logic [PAT_W-1:0] pat;
      logic [LEN_W-1:0] len;
      logic             overlap;
   } cfg_t;

   // Type of the configuration constant applied at reset.
   typedef cfg_t rst_cfg_t;

   // Clamp a requested length into 1..max_len.
   function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] raw,
                                                  input logic [LEN_W-1:0] max_len);
      if (raw == '0)
         return LEN_W'(1);
      else if (raw > max_len)
         return max_len;
      else
         return raw;
   endfunction

endpackage

// File: rtl/seq_detect_match.sv
// Stateless window compare: flags when the newest len bits of {hist, in}
// equal pat[len-1:0] and enough history has been collected to form them.
module seq_detect_match
   import seq_detect_pkg::*;
(
   input  logic [PAT_W-2:0] hist,
   input  logic             in,
   input  logic [PAT_W-1:0] pat,
   input  logic [LEN_W-1:0] len,
   input  logic [LEN_W-1:0] fill,
   output logic             match
);

   logic [PAT_W-1:0] window;
   logic [PAT_W-1:0] mask;
   logic             enough;

   // Compare the low len bits of the candidate window against the pattern.
   always_comb begin
      // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
      window = {hist, in};
      mask   = '0;
      for (int i = 0; i < PAT_W; i++)
         mask[i] = (i < int'(len));
      enough = (({1'b0, fill} + 1'b1) >= {1'b0, len});
      match  = enough && (((window ^ pat) & mask) == '0);
   end

endmodule

// File: rtl/seq_detect_param.sv
// Bit-serial pattern detector with a runtime-loadable pattern, selectable
// overlapping/non-overlapping detection and a Mealy match flag.
// Optional saturating match counter: define SEQDET_COUNT_EN.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                 MAX_LEN = 8,
   parameter logic [MAX_LEN-1:0] RST_PAT = 8'b0000_0110,
   parameter int                 RST_LEN = 4,
   parameter int                 CNT_W   = 16
)(
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   input  logic                         in,
   input  logic                         cfg_load,
   input  logic [MAX_LEN-1:0]           cfg_pat,
   input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
   input  logic                         cfg_overlap,
   output logic                         out
`ifdef SEQDET_COUNT_EN
   ,
   output logic [CNT_W-1:0]             match_cnt
`endif
);

   localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN - 1);
   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
   localparam rst_cfg_t RST_CFG = '{pat: PAT_W'(RST_PAT), len: LEN_W'(RST_LEN), overlap: 1'b0};

   // Reject parameter values outside the supported range at elaboration.
   if (MAX_LEN < 2 || MAX_LEN > PAT_W || RST_LEN < 1 || RST_LEN > MAX_LEN || CNT_W < 1) begin : g_bad_params
      $error("seq_detect_param: parameter out of range");
   end

   cfg_t               cfg_q;
   logic [MAX_LEN-2:0] hist_q;
   logic [LEN_W-1:0]   fill_q;
   logic               accept;
   logic               match_raw;
   logic               hit;

   seq_detect_match u_match (
      .hist  ((PAT_W-1)'(hist_q)),
      .in    (in),
      .pat   (cfg_q.pat),
      .len   (cfg_q.len),
      .fill  (fill_q),
      .match (match_raw)
   );

   // A bit is consumed only when valid and no load is in progress.
   assign accept = in_valid & ~cfg_load;
   assign hit    = accept & match_raw;
   assign out    = rstn & hit;

   // Config, history and fill registers: reset, load, then shift on accepted bits.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
      if (!rstn) begin
         cfg_q  <= RST_CFG;
         // NOTE: hist is cleared on reset for a deterministic start, although fill alone gates its use.
         hist_q <= '0;
         fill_q <= '0;
      end else if (cfg_load) begin
         cfg_q  <= '{pat: PAT_W'(cfg_pat),
                     len: clamp_len(LEN_W'(cfg_len), LEN_MAX),
                     overlap: cfg_overlap};
         fill_q <= '0;
      end else if (in_valid) begin
         hist_q <= (MAX_LEN-1)'({hist_q, in});
         if (hit && !cfg_q.overlap)
            fill_q <= '0;
         else if (fill_q != FILL_MAX)
            fill_q <= fill_q + 1'b1;
      end
   end

`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating count of matches, cleared by reset and by a config load.
   always_ff @(posedge clk) begin
      if (!rstn || cfg_load)
         cnt_q <= '0;
      else if (hit && cnt_q != '1)
         cnt_q <= cnt_q + 1'b1;
   end

   assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed testbench for seq_detect_param. Counter checks are active when
// SEQDET_COUNT_EN is defined (counter built with CNT_W=2).
module tb_seq_detect_param;

   localparam int MAX_LEN = 8;
   localparam int LW      = $clog2(MAX_LEN + 1);
   localparam int CNT_W   = 2;

   logic               clk = 1'b0;
   logic               rstn = 1'b0;
   logic               in_valid = 1'b0;
   logic               in = 1'b0;
   logic               cfg_load = 1'b0;
   logic [MAX_LEN-1:0] cfg_pat = '0;
   logic [LW-1:0]      cfg_len = '0;
   logic               cfg_overlap = 1'b0;
   logic               out;
`ifdef SEQDET_COUNT_EN
   logic [CNT_W-1:0]   match_cnt;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_detect_param #(
      .MAX_LEN (MAX_LEN),
      .RST_PAT (8'b0000_0110),
      .RST_LEN (4),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in          (in),
      .cfg_load    (cfg_load),
      .cfg_pat     (cfg_pat),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .out         (out)
`ifdef SEQDET_COUNT_EN
      ,
      .match_cnt   (match_cnt)
`endif
   );

   // One cycle of serial input; returns mid-cycle with out settled.
   task automatic apply(input logic v, input logic b);
      @(negedge clk);
      cfg_load = 1'b0;
      in_valid = v;
      in       = b;
      #1;
   endtask

   // One cycle of configuration load, optionally with a valid bit alongside.
   task automatic do_load(input logic [7:0] p, input logic [LW-1:0] l, input logic ov,
                          input logic v, input logic b);
      @(negedge clk);
      cfg_load    = 1'b1;
      cfg_pat     = p;
      cfg_len     = l;
      cfg_overlap = ov;
      in_valid    = v;
      in          = b;
      #1;
   endtask

   task automatic test_reset;
      rstn = 1'b0;
      apply(1'b1, 1'b0);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL reset_out_a: out=%b expected 0", out); end
      apply(1'b1, 1'b1);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL reset_out_b: out=%b expected 0", out); end
      rstn = 1'b1;
   endtask

   task automatic test_default;
      logic s[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic e[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, s[i]);
         n_cmp++;
         if (out !== e[i]) begin n_err++; $display("FAIL default_nonoverlap bit %0d: out=%b expected %b", i + 1, out, e[i]); end
      end
`ifdef SEQDET_COUNT_EN
      apply(1'b0, 1'b0);
      n_cmp++;
      if (match_cnt !== 2'd1) begin n_err++; $display("FAIL default_cnt: match_cnt=%0d expected 1", match_cnt); end
`endif
   endtask

   task automatic test_overlap;
      logic s[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic e[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      do_load(8'b0000_0110, LW'(4), 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL overlap_load_out: out=%b expected 0", out); end
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, s[i]);
         n_cmp++;
         if (out !== e[i]) begin n_err++; $display("FAIL overlap bit %0d: out=%b expected %b", i + 1, out, e[i]); end
      end
`ifdef SEQDET_COUNT_EN
      apply(1'b0, 1'b0);
      n_cmp++;
      if (match_cnt !== 2'd2) begin n_err++; $display("FAIL overlap_cnt: match_cnt=%0d expected 2", match_cnt); end
`endif
   endtask

   task automatic test_gaps;
      logic v[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      logic s[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic e[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_load(8'b0000_0110, LW'(4), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) begin
         apply(v[i], s[i]);
         n_cmp++;
         if (out !== e[i]) begin n_err++; $display("FAIL gaps cycle %0d: out=%b expected %b", i + 1, out, e[i]); end
      end
   endtask

   task automatic test_load_collision;
      logic s1[3] = '{1'b0, 1'b1, 1'b1};
      logic s2[2] = '{1'b0, 1'b1};
      logic s3[2] = '{1'b1, 1'b0};
      logic s4[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic e4[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, s1[i]);
         n_cmp++;
         if (out !== 1'b0) begin n_err++; $display("FAIL collision_prefix bit %0d: out=%b expected 0", i + 1, out); end
      end
      do_load(8'b0000_0110, LW'(4), 1'b0, 1'b1, 1'b0);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL collision_load_out: out=%b expected 0", out); end
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, s2[i]);
         n_cmp++;
         if (out !== 1'b0) begin n_err++; $display("FAIL collision_s2 bit %0d: out=%b expected 0", i + 1, out); end
      end
      do_load(8'b0000_0110, LW'(4), 1'b0, 1'b1, 1'b1);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL collision_load2_out: out=%b expected 0", out); end
      for (int i = 0; i < 2; i++) begin
         apply(1'b1, s3[i]);
         n_cmp++;
         if (out !== 1'b0) begin n_err++; $display("FAIL collision_fresh bit %0d: out=%b expected 0", i + 1, out); end
      end
      for (int i = 0; i < 4; i++) begin
         apply(1'b1, s4[i]);
         n_cmp++;
         if (out !== e4[i]) begin n_err++; $display("FAIL collision_rematch bit %0d: out=%b expected %b", i + 1, out, e4[i]); end
      end
   endtask

   task automatic test_len1;
      logic s[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic e[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      do_load(8'b0000_0001, LW'(1), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         apply(1'b1, s[i]);
         n_cmp++;
         if (out !== e[i]) begin n_err++; $display("FAIL len1 bit %0d: out=%b expected %b", i + 1, out, e[i]); end
      end
`ifdef SEQDET_COUNT_EN
      apply(1'b0, 1'b0);
      n_cmp++;
      if (match_cnt !== 2'd3) begin n_err++; $display("FAIL len1_cnt_saturate: match_cnt=%0d expected 3", match_cnt); end
`endif
   endtask

   task automatic test_clamp;
      logic s0[3] = '{1'b0, 1'b1, 1'b1};
      logic e0[3] = '{1'b0, 1'b1, 1'b1};
      logic s8[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
      logic e8[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      do_load(8'b0000_0001, LW'(0), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, s0[i]);
         n_cmp++;
         if (out !== e0[i]) begin n_err++; $display("FAIL clamp_len0 bit %0d: out=%b expected %b", i + 1, out, e0[i]); end
      end
      do_load(8'b1011_0011, LW'(15), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 9; i++) begin
         apply(1'b1, s8[i]);
         n_cmp++;
         if (out !== e8[i]) begin n_err++; $display("FAIL clamp_len_max bit %0d: out=%b expected %b", i + 1, out, e8[i]); end
      end
   endtask

   task automatic test_reset_midstream;
      logic s1[3] = '{1'b0, 1'b1, 1'b1};
      logic s2[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      logic e2[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
      for (int i = 0; i < 3; i++) begin
         apply(1'b1, s1[i]);
         n_cmp++;
         if (out !== 1'b0) begin n_err++; $display("FAIL midreset_prefix bit %0d: out=%b expected 0", i + 1, out); end
      end
      rstn = 1'b0;
      apply(1'b1, 1'b0);
      n_cmp++;
      if (out !== 1'b0) begin n_err++; $display("FAIL midreset_out: out=%b expected 0", out); end
      rstn = 1'b1;
      for (int i = 0; i < 7; i++) begin
         apply(1'b1, s2[i]);
         n_cmp++;
         if (out !== e2[i]) begin n_err++; $display("FAIL midreset_after bit %0d: out=%b expected %b", i + 1, out, e2[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_default();
      test_overlap();
      test_gaps();
      test_load_collision();
      test_len1();
      test_clamp();
      test_reset_midstream();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
